// File: rtl/suma_serie_ctrl_pkg.sv
// Shared calculator definitions: sequencer state encoding and operation codes.
package suma_serie_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/sumador_completo.sv
// One-bit full-adder slice, time-shared by the serial sequencer.
module sumador_completo (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/suma_serie_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice run LSB-first over WIDTH cycles.
module suma_serie_ctrl
    import suma_serie_ctrl_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   x
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             c_q, c_d;
    logic             opq_q, opq_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   x_q, x_d;

    logic             s, cout;

    sumador_completo u_slice (
        .a   (sa_q[0]),
        .b   (sb_q[0]),
        .cin (c_q),
        .s   (s),
        .cout(cout)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        c_d     = c_q;
        opq_d   = opq_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    sa_d    = a;
                    // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
                    sb_d    = (op == OP_SUB) ? ~b : b;
                    c_d     = op;
                    opq_d   = op;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                c_d   = cout;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = {s, sr_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    // Carry out of a subtraction means no borrow, so it is inverted.
                    x_d     = {(opq_q == OP_SUB) ? ~cout : cout, s, sr_q[WIDTH-1:1]};
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            opq_q   <= 1'b0;
            cnt_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            opq_q   <= opq_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign x    = x_q;

endmodule

// File: tb/tb_suma_serie_ctrl.sv
// Self-checking bench for suma_serie_ctrl (WIDTH=5) against an arithmetic reference model.
module tb_suma_serie_ctrl;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst, start, op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W:0]   x;

    int total = 0;
    int bad   = 0;

    suma_serie_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .x    (x)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_model(input logic o, input logic [W-1:0] ia, input logic [W-1:0] ib);
        int ai, bi, r;
        ai = int'(ia);
        bi = int'(ib);
        if (o == 1'b0) r = ai + bi;
        else           r = ((ai - bi + 32) % 32) + ((ai < bi) ? 32 : 0);
        return r[W:0];
    endfunction

    // Called at a negedge; returns at the first negedge with busy=0 after done.
    task automatic run_op(input logic o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output logic [W:0] xr, output logic [W:0] x0,
                          output int didx, output int nd, output int nbusy);
        start = 1'b1; op = o; a = ia; b = ib;
        @(negedge clk);
        start = 1'b0; op = 1'($urandom); a = W'($urandom); b = W'($urandom);
        x0 = x; xr = '0; didx = -1; nd = 0; nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) nbusy++;
            if (done) begin
                nd++;
                if (didx < 0) begin didx = i; xr = x; end
            end
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (x !== '0)      begin bad++; $display("FAIL reset_x got=%0d want=0", x); end
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [W:0] xr, x0; int didx, nd, nb;
        run_op(1'b0, 5'd5, 5'd3, xr, x0, didx, nd, nb);
        total++; if (xr !== 6'd8) begin bad++; $display("FAIL add_5_3 got=%0d want=8", xr); end
        total++; if (didx != W) begin bad++; $display("FAIL add_latency got=%0d want=%0d", didx, W); end
        total++; if (nb != W + 1) begin bad++; $display("FAIL add_busy_cycles got=%0d want=%0d", nb, W + 1); end
        total++; if (nd != 1) begin bad++; $display("FAIL add_done_count got=%0d want=1", nd); end
        run_op(1'b0, 5'd31, 5'd31, xr, x0, didx, nd, nb);
        total++; if (xr !== 6'd62) begin bad++; $display("FAIL add_31_31 got=%0d want=62", xr); end
        total++; if (x0 !== 6'd8) begin bad++; $display("FAIL x_hold got=%0d want=8", x0); end
    endtask

    task automatic test_sub();
        logic [W:0] xr, x0; int didx, nd, nb;
        run_op(1'b1, 5'd9, 5'd7, xr, x0, didx, nd, nb);
        total++; if (xr !== 6'b000010) begin bad++; $display("FAIL sub_9_7 got=%b want=000010", xr); end
        run_op(1'b1, 5'd7, 5'd9, xr, x0, didx, nd, nb);
        total++; if (xr !== 6'b111110) begin bad++; $display("FAIL sub_7_9 got=%b want=111110", xr); end
        run_op(1'b1, 5'd0, 5'd0, xr, x0, didx, nd, nb);
        total++; if (xr !== 6'd0) begin bad++; $display("FAIL sub_0_0 got=%b want=000000", xr); end
    endtask

    task automatic test_start_while_busy();
        int nd = 0;
        start = 1'b1; op = 1'b0; a = 5'd1; b = 5'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (done) nd++;
            if (i == 1) begin start = 1'b1; a = 5'd10; b = 5'd10; end
            if (i == 2) start = 1'b0;
            @(negedge clk);
        end
        total++; if (x !== 6'd2) begin bad++; $display("FAIL ignore_start_x got=%0d want=2", x); end
        total++; if (nd != 1) begin bad++; $display("FAIL ignore_start_done got=%0d want=1", nd); end
    endtask

    task automatic test_abort();
        logic [W:0] xr, x0; int didx, nd, nb; int late = 0;
        start = 1'b1; op = 1'b1; a = 5'd20; b = 5'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
        total++; if (x !== '0) begin bad++; $display("FAIL abort_x got=%0d want=0", x); end
        for (int i = 0; i < 10; i++) begin
            if (done || busy) late++;
            @(negedge clk);
        end
        total++; if (late != 0) begin bad++; $display("FAIL abort_late_activity got=%0d want=0", late); end
        run_op(1'b0, 5'd4, 5'd4, xr, x0, didx, nd, nb);
        total++; if (xr !== 6'd8) begin bad++; $display("FAIL after_abort_add got=%0d want=8", xr); end
    endtask

    task automatic test_back_to_back();
        logic [W:0] xr, x0; int didx, nd, nb;
        run_op(1'b0, 5'd12, 5'd9, xr, x0, didx, nd, nb);
        total++; if (xr !== 6'd21) begin bad++; $display("FAIL b2b_first got=%0d want=21", xr); end
        // run_op returned on the first busy=0 cycle: issue immediately.
        run_op(1'b0, 5'd3, 5'd4, xr, x0, didx, nd, nb);
        total++; if (xr !== 6'd7) begin bad++; $display("FAIL b2b_second got=%0d want=7", xr); end
        total++; if (didx != W) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", didx + 1, W + 1); end
    endtask

    task automatic test_random();
        logic [W:0] xr, x0, exp_x, prev;
        logic       ro;
        logic [W-1:0] ra, rb;
        int didx, nd, nb;
        prev = x;
        for (int n = 0; n < 40; n++) begin
            ro = 1'($urandom); ra = W'($urandom); rb = W'($urandom);
            exp_x = ref_model(ro, ra, rb);
            run_op(ro, ra, rb, xr, x0, didx, nd, nb);
            total++;
            if (xr !== exp_x || didx != W || nd != 1 || x0 !== prev) begin
                bad++;
                $display("FAIL rand_%0d op=%b a=%0d b=%0d got x=%0d lat=%0d dones=%0d hold=%0d want x=%0d lat=%0d dones=1 hold=%0d",
                         n, ro, ra, rb, xr, didx, nd, x0, exp_x, W, prev);
            end
            prev = exp_x;
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_start_while_busy();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
